multicycle_controller: RTL

- Control FSM for the multicycle RV32I-subset core. Decodes the opcode and sequences a shared datapath: one memory port, one ALU, and the PC/IR/register-file writes.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
- Handshakes with instruction/data memory through mem_req/mem_ready.
- Traps on any unsupported opcode.

---
 rtl/controller_pkg.sv | 63 ++++++
 rtl/alu_op_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: FSM states,
// opcodes, ALU operation/control codes and datapath mux selects.
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_decode(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps the FSM's coarse alu_op plus instruction fields to an ALU control code.
// Purely combinational, zero latency, no flow control.
module alu_op_decoder
  import controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          // Only R-type (op5=1) can encode sub; addi with bit30 set is still add.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: lw 5, sw/R/I/jal 4, beq 3 cycles plus one
// per mem_ready=0 cycle; memory waits hold every request/select stable.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       retire,
  output logic       illegal
);

  // An unsupported parameter value brings the core up trapped rather than running.
  localparam state_t RESET_STATE = (RESET_STATE_FETCH == 1) ? S_FETCH : S_TRAP;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       mem_req_s, ir_write_s, pc_update, branch;
  logic       mem_write_s, reg_write_s, retire_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_s   = 1'b0;
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    retire_s    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_op      = ALU_OP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_update  = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // ALUOut holds the target from DECODE; ALU computes the link PC+4 here.
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  alu_op_decoder u_alu_op_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // Strobes are masked while reset is held so nothing fires before the first fetch.
  assign mem_req   = rst_n & mem_req_s;
  assign ir_write  = rst_n & ir_write_s;
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign mem_write = rst_n & mem_write_s;
  assign reg_write = rst_n & reg_write_s;
  assign retire    = rst_n & retire_s;
  assign illegal   = (state_q == S_TRAP);
  assign imm_src   = imm_decode(op);

endmodule
